// File: rtl/kalman_fpu_arbiter.sv
// Round-robin sharing of one pipelined float32 adder and one multiplier among N_REQ Kalman stages.
// Each unit has its own arbiter, operand registers and tag pipe that routes results back to the issuer.
module kalman_fpu_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADD_LAT = 11,
    parameter int MUL_LAT = 11
) (
    input  logic                  clk_50M,
    input  logic                  Rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [2*N_REQ-1:0]    req_op,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [31:0]           add_dataa,
    output logic [31:0]           add_datab,
    output logic                  add_sub,
    input  logic [31:0]           add_result,
    output logic [31:0]           mult_dataa,
    output logic [31:0]           mult_datab,
    input  logic [31:0]           mult_result,
    output logic [N_REQ-1:0]      rsp_add_valid,
    output logic [31:0]           rsp_add_data,
    output logic [N_REQ-1:0]      rsp_mul_valid,
    output logic [31:0]           rsp_mul_data
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IW-1:0]    add_ptr_q, add_ptr_d, mul_ptr_q, mul_ptr_d;
    logic [N_REQ-1:0] add_cand, mul_cand, add_gnt, mul_gnt;
    logic [IW-1:0]    add_idx, mul_idx;

    logic [31:0]      add_dataa_q, add_dataa_d, add_datab_q, add_datab_d;
    logic             add_sub_q, add_sub_d;
    logic [31:0]      mult_dataa_q, mult_dataa_d, mult_datab_q, mult_datab_d;

    logic [ADD_LAT:0] add_vld_q, add_vld_d;
    logic [MUL_LAT:0] mul_vld_q, mul_vld_d;
    logic [IW-1:0]    add_tag_q [ADD_LAT+1];
    logic [IW-1:0]    add_tag_d [ADD_LAT+1];
    logic [IW-1:0]    mul_tag_q [MUL_LAT+1];
    logic [IW-1:0]    mul_tag_d [MUL_LAT+1];

    logic [N_REQ-1:0] rsp_add_valid_q, rsp_add_valid_d, rsp_mul_valid_q, rsp_mul_valid_d;
    logic [31:0]      rsp_add_data_q, rsp_add_data_d, rsp_mul_data_q, rsp_mul_data_d;

    // First candidate at or after ptr, wrapping modulo N_REQ; result is one-hot or zero.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] cand,
                                                 input logic [IW-1:0] ptr);
        logic [N_REQ-1:0] gnt;
        logic             found;
        int               j;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && cand[j]) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [IW-1:0] oh2idx(input logic [N_REQ-1:0] oh);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (oh[i]) idx = IW'(i);
        return idx;
    endfunction

    function automatic logic [N_REQ-1:0] idx2oh(input logic [IW-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_REQ; i++)
            if (idx == IW'(i)) oh[i] = 1'b1;
        return oh;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] idx);
        return (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        add_cand = '0;
        mul_cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            add_cand[i] = req_valid[i] & ~req_op[2*i+1];
            mul_cand[i] = req_valid[i] & req_op[2*i+1] & ~req_op[2*i];
        end
        add_gnt   = Rst ? '0 : rr_pick(add_cand, add_ptr_q);
        mul_gnt   = Rst ? '0 : rr_pick(mul_cand, mul_ptr_q);
        add_idx   = oh2idx(add_gnt);
        mul_idx   = oh2idx(mul_gnt);
        req_ready = add_gnt | mul_gnt;
    end

    always_comb begin
        add_ptr_d    = add_ptr_q;
        mul_ptr_d    = mul_ptr_q;
        add_dataa_d  = add_dataa_q;
        add_datab_d  = add_datab_q;
        add_sub_d    = add_sub_q;
        mult_dataa_d = mult_dataa_q;
        mult_datab_d = mult_datab_q;
        if (|add_gnt) add_ptr_d = next_ptr(add_idx);
        if (|mul_gnt) mul_ptr_d = next_ptr(mul_idx);
        for (int i = 0; i < N_REQ; i++) begin
            if (add_gnt[i]) begin
                add_dataa_d = req_a[32*i +: 32];
                add_datab_d = req_b[32*i +: 32];
                add_sub_d   = req_op[2*i];
            end
            if (mul_gnt[i]) begin
                mult_dataa_d = req_a[32*i +: 32];
                mult_datab_d = req_b[32*i +: 32];
            end
        end

        // Tag stage k holds the op issued k+1 edges ago; the last stage lines up with x_result.
        add_vld_d    = {add_vld_q[ADD_LAT-1:0], |add_gnt};
        mul_vld_d    = {mul_vld_q[MUL_LAT-1:0], |mul_gnt};
        add_tag_d[0] = add_idx;
        mul_tag_d[0] = mul_idx;
        for (int k = 1; k <= ADD_LAT; k++) add_tag_d[k] = add_tag_q[k-1];
        for (int k = 1; k <= MUL_LAT; k++) mul_tag_d[k] = mul_tag_q[k-1];

        rsp_add_valid_d = add_vld_q[ADD_LAT] ? idx2oh(add_tag_q[ADD_LAT]) : '0;
        rsp_mul_valid_d = mul_vld_q[MUL_LAT] ? idx2oh(mul_tag_q[MUL_LAT]) : '0;
        rsp_add_data_d  = add_vld_q[ADD_LAT] ? add_result  : rsp_add_data_q;
        rsp_mul_data_d  = mul_vld_q[MUL_LAT] ? mult_result : rsp_mul_data_q;
    end

    always_ff @(posedge clk_50M) begin
        if (Rst) begin
            add_ptr_q       <= '0;
            mul_ptr_q       <= '0;
            add_dataa_q     <= '0;
            add_datab_q     <= '0;
            add_sub_q       <= 1'b0;
            mult_dataa_q    <= '0;
            mult_datab_q    <= '0;
            add_vld_q       <= '0;
            mul_vld_q       <= '0;
            for (int k = 0; k <= ADD_LAT; k++) add_tag_q[k] <= '0;
            for (int k = 0; k <= MUL_LAT; k++) mul_tag_q[k] <= '0;
            rsp_add_valid_q <= '0;
            rsp_mul_valid_q <= '0;
            rsp_add_data_q  <= '0;
            rsp_mul_data_q  <= '0;
        end else begin
            add_ptr_q       <= add_ptr_d;
            mul_ptr_q       <= mul_ptr_d;
            add_dataa_q     <= add_dataa_d;
            add_datab_q     <= add_datab_d;
            add_sub_q       <= add_sub_d;
            mult_dataa_q    <= mult_dataa_d;
            mult_datab_q    <= mult_datab_d;
            add_vld_q       <= add_vld_d;
            mul_vld_q       <= mul_vld_d;
            for (int k = 0; k <= ADD_LAT; k++) add_tag_q[k] <= add_tag_d[k];
            for (int k = 0; k <= MUL_LAT; k++) mul_tag_q[k] <= mul_tag_d[k];
            rsp_add_valid_q <= rsp_add_valid_d;
            rsp_mul_valid_q <= rsp_mul_valid_d;
            rsp_add_data_q  <= rsp_add_data_d;
            rsp_mul_data_q  <= rsp_mul_data_d;
        end
    end

    assign add_dataa     = add_dataa_q;
    assign add_datab     = add_datab_q;
    assign add_sub       = add_sub_q;
    assign mult_dataa    = mult_dataa_q;
    assign mult_datab    = mult_datab_q;
    assign rsp_add_valid = rsp_add_valid_q;
    assign rsp_add_data  = rsp_add_data_q;
    assign rsp_mul_valid = rsp_mul_valid_q;
    assign rsp_mul_data  = rsp_mul_data_q;

endmodule

// File: tb/tb_kalman_fpu_arbiter.sv
// Bench for kalman_fpu_arbiter: behavioural float cores, arbiter vector table, scoreboard on responses,
// and hand-written sequences for the multi-cycle cases.
module tb_kalman_fpu_arbiter;

    localparam int N  = 4;
    localparam int AL = 11;
    localparam int ML = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [2*N-1:0]  req_op;
    logic [32*N-1:0] req_a, req_b;
    logic [N-1:0]    req_ready;
    logic [31:0]     add_dataa, add_datab, add_result;
    logic            add_sub;
    logic [31:0]     mult_dataa, mult_datab, mult_result;
    logic [N-1:0]    rsp_add_valid, rsp_mul_valid;
    logic [31:0]     rsp_add_data, rsp_mul_data;

    always #5 clk = ~clk;

    kalman_fpu_arbiter #(.N_REQ(N), .ADD_LAT(AL), .MUL_LAT(ML)) dut (
        .clk_50M(clk), .Rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .add_dataa(add_dataa), .add_datab(add_datab), .add_sub(add_sub), .add_result(add_result),
        .mult_dataa(mult_dataa), .mult_datab(mult_datab), .mult_result(mult_result),
        .rsp_add_valid(rsp_add_valid), .rsp_add_data(rsp_add_data),
        .rsp_mul_valid(rsp_mul_valid), .rsp_mul_data(rsp_mul_data)
    );

    // float32 <-> real for normal values; denormals flush to zero.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:23] == 8'd0) d = {f[31], 63'd0};
        else begin
            e = {3'b000, f[30:23]} + 11'd896;
            d = {f[31], e, f[22:0], 29'd0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e < 11'd897) return {d[63], 31'd0};
        e = e - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return r2f(f2r(a) + f2r(b));
            2'b01:   return r2f(f2r(a) - f2r(b));
            default: return r2f(f2r(a) * f2r(b));
        endcase
    endfunction

    logic [31:0] add_pipe [AL];
    logic [31:0] mul_pipe [ML];
    always @(posedge clk) begin
        add_pipe[0] <= model({1'b0, add_sub}, add_dataa, add_datab);
        mul_pipe[0] <= model(2'b10, mult_dataa, mult_datab);
        for (int k = 1; k < AL; k++) add_pipe[k] <= add_pipe[k-1];
        for (int k = 1; k < ML; k++) mul_pipe[k] <= mul_pipe[k-1];
    end
    assign add_result  = add_pipe[AL-1];
    assign mult_result = mul_pipe[ML-1];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t add_q[$];
    exp_t mul_q[$];

    // Accepts are sampled mid-cycle, ahead of the edge that registers them.
    always @(negedge clk) begin
        exp_t e;
        logic [1:0] op;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                op     = req_op[2*i +: 2];
                e.idx  = i;
                e.data = model(op, req_a[32*i +: 32], req_b[32*i +: 32]);
                if (op == 2'b10) begin
                    e.due = cyc + 1 + ML + 1;
                    mul_q.push_back(e);
                end else begin
                    e.due = cyc + 1 + AL + 1;
                    add_q.push_back(e);
                end
            end
        end
        if (rsp_add_valid != '0) begin
            if (add_q.size() == 0) chk("add_unexpected", 64'(rsp_add_valid), 64'd0);
            else begin
                e = add_q.pop_front();
                chk("add_dest", 64'(rsp_add_valid), 64'(1 << e.idx));
                chk("add_data", 64'(rsp_add_data), 64'(e.data));
                chk("add_latency", 64'(cyc), 64'(e.due));
            end
        end
        if (add_q.size() > 0 && add_q[0].due < cyc) begin
            chk("add_missing", 64'(cyc), 64'(add_q[0].due));
            void'(add_q.pop_front());
        end
        if (rsp_mul_valid != '0) begin
            if (mul_q.size() == 0) chk("mul_unexpected", 64'(rsp_mul_valid), 64'd0);
            else begin
                e = mul_q.pop_front();
                chk("mul_dest", 64'(rsp_mul_valid), 64'(1 << e.idx));
                chk("mul_data", 64'(rsp_mul_data), 64'(e.data));
                chk("mul_latency", 64'(cyc), 64'(e.due));
            end
        end
        if (mul_q.size() > 0 && mul_q[0].due < cyc) begin
            chk("mul_missing", 64'(cyc), 64'(mul_q[0].due));
            void'(mul_q.pop_front());
        end
    end

    typedef struct {
        logic [3:0] valid;
        logic [7:0] op;
        logic [3:0] ready;
    } vec_t;
    vec_t tbl[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        add_q.delete();
        mul_q.delete();
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[2*i +: 2]  = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [31:0] mul_exp [6];

    initial begin
        // Arbiter vectors applied one per cycle from reset pointers {add=0, mul=0}.
        tbl[0]  = '{4'b0001, 8'h00, 4'b0001};
        tbl[1]  = '{4'b1111, 8'h00, 4'b0010};
        tbl[2]  = '{4'b1111, 8'h00, 4'b0100};
        tbl[3]  = '{4'b1111, 8'h00, 4'b1000};
        tbl[4]  = '{4'b1111, 8'h00, 4'b0001};
        tbl[5]  = '{4'b0001, 8'h02, 4'b0001};
        tbl[6]  = '{4'b0011, 8'h0A, 4'b0010};
        tbl[7]  = '{4'b1111, 8'h88, 4'b1100};
        tbl[8]  = '{4'b1111, 8'hFF, 4'b0000};
        tbl[9]  = '{4'b1000, 8'hC0, 4'b0000};
        tbl[10] = '{4'b0111, 8'hC0, 4'b0001};
        tbl[11] = '{4'b0000, 8'h00, 4'b0000};
        mul_exp[0] = 32'h40000000; mul_exp[1] = 32'h40800000; mul_exp[2] = 32'h40C00000;
        mul_exp[3] = 32'h41000000; mul_exp[4] = 32'h41200000; mul_exp[5] = 32'h41400000;

        rst = 1'b1;
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        tick();
        req_valid = 4'b1111;
        @(negedge clk);
        chk("ready_in_reset", 64'(req_ready), 64'd0);
        tick();
        req_valid = '0;
        rst = 1'b0;
        add_q.delete();
        mul_q.delete();
        chk("rst_add_dataa", 64'(add_dataa), 64'd0);
        chk("rst_add_sub", 64'(add_sub), 64'd0);
        chk("rst_mult_datab", 64'(mult_datab), 64'd0);
        chk("rst_rsp_add_valid", 64'(rsp_add_valid), 64'd0);
        chk("rst_rsp_mul_data", 64'(rsp_mul_data), 64'd0);

        req_a = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        req_b = {4{32'h3F000000}};
        for (int v = 0; v < 12; v++) begin
            req_valid = tbl[v].valid;
            req_op    = tbl[v].op;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(tbl[v].ready));
            tick();
        end
        req_valid = '0;
        repeat (16) tick();

        // Single add: registered operands at E, response at E+12.
        set_req(0, 2'b00, 32'h3F800000, 32'h40000000);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_ready", 64'(req_ready), 64'h1);
        tick();
        chk("t1_add_dataa", 64'(add_dataa), 64'h3F800000);
        chk("t1_add_datab", 64'(add_datab), 64'h40000000);
        chk("t1_add_sub", 64'(add_sub), 64'd0);
        req_valid = '0;
        tick();
        chk("t1_operand_hold", 64'(add_dataa), 64'h3F800000);
        repeat (11) @(posedge clk);
        #1;
        chk("t1_rsp_valid", 64'(rsp_add_valid), 64'h1);
        chk("t1_rsp_data", 64'(rsp_add_data), 64'h40400000);
        repeat (4) tick();

        // Sub and mul accepted together, returning together.
        set_req(1, 2'b01, 32'h40400000, 32'h3F800000);
        set_req(2, 2'b10, 32'h40000000, 32'h3F000000);
        req_valid = 4'b0110;
        @(negedge clk);
        chk("t2_ready", 64'(req_ready), 64'h6);
        tick();
        chk("t2_add_sub", 64'(add_sub), 64'd1);
        chk("t2_mult_dataa", 64'(mult_dataa), 64'h40000000);
        req_valid = '0;
        repeat (12) @(posedge clk);
        #1;
        chk("t2_add_valid", 64'(rsp_add_valid), 64'h2);
        chk("t2_add_data", 64'(rsp_add_data), 64'h40000000);
        chk("t2_mul_valid", 64'(rsp_mul_valid), 64'h4);
        chk("t2_mul_data", 64'(rsp_mul_data), 64'h3F800000);
        repeat (4) tick();

        // Full contention from reset pointers.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 2'b00, 32'h3F800000 + (i << 23), 32'h3F800000);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("t3_grant%0d", c), 64'(req_ready), 64'(1 << (c % 4)));
            tick();
        end
        req_valid = '0;
        repeat (16) tick();

        // Illegal op held while requester 0 streams adds.
        set_req(3, 2'b11, 32'h40000000, 32'h40000000);
        set_req(0, 2'b00, 32'h3F800000, 32'h3F800000);
        req_valid = 4'b1001;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("t4_ready%0d", c), 64'(req_ready), 64'h1);
            tick();
        end
        req_valid = '0;
        repeat (16) tick();

        // Reset with five adds in flight.
        set_req(0, 2'b00, 32'h40000000, 32'h40000000);
        req_valid = 4'b0001;
        repeat (5) tick();
        req_valid = '0;
        repeat (4) tick();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk($sformatf("t5_no_rsp%0d", c), 64'(rsp_add_valid), 64'd0);
            tick();
        end
        set_req(1, 2'b00, 32'h40400000, 32'h40400000);
        req_valid = 4'b0011;
        @(negedge clk);
        chk("t5_ptr_reset", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        repeat (16) tick();

        // Back-to-back muls from one requester.
        req_valid = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            set_req(0, 2'b10, 32'h3F800000 + (c == 0 ? 32'h0 :
                              c == 1 ? 32'h00800000 : c == 2 ? 32'h00C00000 :
                              c == 3 ? 32'h01000000 : c == 4 ? 32'h01200000 : 32'h01400000),
                    32'h40000000);
            @(negedge clk);
            chk($sformatf("t6_ready%0d", c), 64'(req_ready), 64'h1);
            tick();
        end
        req_valid = '0;
        repeat (7) @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("t6_mul_valid%0d", c), 64'(rsp_mul_valid), 64'h1);
            chk($sformatf("t6_mul_data%0d", c), 64'(rsp_mul_data), 64'(mul_exp[c]));
            tick();
        end
        repeat (16) tick();

        chk("add_q_drained", 64'(add_q.size()), 64'd0);
        chk("mul_q_drained", 64'(mul_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
